zhiwen_ack_rx: RTL
==================

# zhiwen_ack_rx

Fingerprint-sensor acknowledgment parser: the receive-side counterpart of the fingerprint command-request logic. It consumes the byte stream from the UART receiver attached to the sensor's TX line and frames sensor reply packets (header 0xEF01, 32-bit address, PID, 16-bit length, payload, 16-bit checksum). It validates each packet and presents the confirmation code, matched page ID and match score to the lock control FSM as a single-cycle result strobe.

## Interface
- `DEV_ADDR`, default 32'hFFFF_FFFF: expected sensor address field.
- `MAX_LEN`, default 16: largest accepted LEN field value.
- `TIMEOUT_CYC`, default 2_500_000: inter-byte idle limit in clk cycles (50 ms at 50 MHz).

Ports:
- `clk`, input, 1: system clock.
- `rst_n`, input, 1: reset. Asynchronous, active-low.
- `rx_byte`, input, 8: received byte. Valid only while rx_vld=1.
- `rx_vld`, input, 1: one-cycle byte strobe from the UART RX. Back-to-back every cycle is allowed.
- `busy`, output, 1: high while a packet is partially received (state not HUNT_H0).
- `resp_vld`, output, 1: one-cycle pulse when a valid ack packet has completed.
- `confirm_code`, output, 8: payload byte 0 of the last valid packet.
- `page_id`, output, 16: payload bytes 1–2 of the last valid packet, big-endian.
- `score`, output, 16: payload bytes 3–4 of the last valid packet, big-endian.
- `chk_err`, output, 1: one-cycle pulse when a packet's checksum does not match.
- `fmt_err`, output, 1: one-cycle pulse on an address, PID or LEN violation.
- `timeout`, output, 1: one-cycle pulse when a packet is aborted by the inter-byte timer.

## Operation
- Reset values: every output is 0 and the state is HUNT_H0.
- States, in order: HUNT_H0, HUNT_H1, ADDR (4 bytes, MSB first), PID, LEN_H, LEN_L, DATA (LEN−2 bytes), SUM_H, SUM_L. The FSM advances only on rx_vld.
- HUNT_H0: byte 0xEF goes to HUNT_H1; any other byte stays in HUNT_H0.
- HUNT_H1: 0x01 goes to ADDR; 0xEF stays in HUNT_H1; any other byte returns to HUNT_H0. These hunt mismatches raise no error.
- ADDR: if the assembled address ≠ DEV_ADDR, pulse fmt_err and go to HUNT_H0 after the 4th byte.
- PID: must equal 0x07 (ack). Otherwise pulse fmt_err and go to HUNT_H0.
- LEN: the value must satisfy 3 ≤ LEN ≤ MAX_LEN. Otherwise pulse fmt_err and go to HUNT_H0 after LEN_L.
- Checksum: 16-bit accumulator, mod 2^16. It is cleared at PID and adds the zero-extended PID, LEN_H, LEN_L and every DATA byte.
- SUM_L compares the accumulator with {SUM_H, SUM_L}.
  - Match: pulse resp_vld and update the fields.
  - Mismatch: pulse chk_err; fields are unchanged.
  - Either way, return to HUNT_H0.
- Field capture:
  - Payload bytes are staged internally and copied to the outputs only on a valid packet.
  - Payload bytes not present (LEN < 7) are written as 0.
  - Payload bytes beyond index 4 are checksummed and then discarded.
- confirm_code, page_id and score hold their values between packets.

## Timing
- All outputs are registered.
- resp_vld, chk_err or fmt_err assert in the cycle after the clk edge that samples the deciding byte. Fields are valid in the same cycle as resp_vld.
- Only one of the pulse outputs is ever high in a given cycle.
- Inter-byte timer:
  - Runs whenever the state is not HUNT_H0 and is cleared by each rx_vld.
  - On reaching TIMEOUT_CYC−1 with no byte: pulse timeout and force HUNT_H0; staged data is discarded.
  - If rx_vld coincides with expiry, the byte wins: it is processed normally and the timer clears.
- A byte arriving in the cycle after a pulse is processed from HUNT_H0 with no dead cycle.
- rst_n asserted mid-packet: immediate return to reset values; the partial packet is lost.

## Configuration
- `ZHIWEN_ACK_TIMEOUT_EN` defined: inter-byte timer instantiated as described above.
- Not defined: no timer logic is built, `timeout` is tied to 0, and a stalled packet waits indefinitely (only rst_n or further bytes recover it).

## Structure
- Shared package `zhiwen_pkg`:
  - Constants: HDR0=8'hEF, HDR1=8'h01, PID_ACK=8'h07, confirm codes (OK=8'h00, NOT_FOUND=8'h09).
  - Typedef: the parser state encoding.
- One sub-module, `zhiwen_byte_timer`: clear and enable inputs, expiry output. It is instantiated only under ZHIWEN_ACK_TIMEOUT_EN.

## Test plan
- Search ack EF 01 FF FF FF FF 07 00 07 00 00 05 00 64 00 77 → resp_vld once; confirm_code=00, page_id=0005, score=0064.
- Short ack EF 01 FF FF FF FF 07 00 03 09 00 13 → resp_vld; confirm_code=09, page_id=0000, score=0000.
- First packet with final byte changed to 78 → chk_err once, no resp_vld, fields keep their prior values.
- Noise 12 EF EF 01 followed by the short-ack body → resync; resp_vld with confirm_code=09. PID 01 instead → fmt_err.
- Stop after LEN_L, idle TIMEOUT_CYC cycles → timeout pulse, busy=0. A following full packet parses correctly. A byte on the expiry cycle → no timeout.
- rst_n low mid-DATA, then a full packet → all outputs 0 during reset; the packet is then accepted normally.

Source files
------------

// File: rtl/zhiwen_pkg.sv
// rtl/zhiwen_pkg.sv - shared constants and parser state encoding for the fingerprint ack receiver
package zhiwen_pkg;

  localparam logic [7:0] HDR0         = 8'hEF;
  localparam logic [7:0] HDR1         = 8'h01;
  localparam logic [7:0] PID_ACK      = 8'h07;
  localparam logic [7:0] CC_OK        = 8'h00;
  localparam logic [7:0] CC_NOT_FOUND = 8'h09;

  typedef enum logic [3:0] {
    ST_HUNT_H0,
    ST_HUNT_H1,
    ST_ADDR,
    ST_PID,
    ST_LEN_H,
    ST_LEN_L,
    ST_DATA,
    ST_SUM_H,
    ST_SUM_L
  } state_t;

endpackage

// File: rtl/zhiwen_byte_timer.sv
// rtl/zhiwen_byte_timer.sv - inter-byte idle counter; o_expire is high on the cycle the limit is reached
module zhiwen_byte_timer #(
  parameter int unsigned TIMEOUT_CYC = 2_500_000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expire
);

  localparam int unsigned    CW   = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CW-1:0]  LAST = CW'(TIMEOUT_CYC - 1);

  logic [CW-1:0] r_cnt;

  // A byte on the expiry cycle clears the timer instead of letting it fire.
  assign o_expire = i_en && !i_clr && (r_cnt == LAST);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clr || !i_en || o_expire) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/zhiwen_ack_rx.sv
// rtl/zhiwen_ack_rx.sv - frames and validates sensor ack packets; ZHIWEN_ACK_TIMEOUT_EN adds the inter-byte timer
module zhiwen_ack_rx
  import zhiwen_pkg::*;
#(
  parameter logic [31:0] DEV_ADDR    = 32'hFFFF_FFFF,
  parameter int unsigned MAX_LEN     = 16,
  parameter int unsigned TIMEOUT_CYC = 2_500_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_byte,
  input  logic        rx_vld,
  output logic        busy,
  output logic        resp_vld,
  output logic [7:0]  confirm_code,
  output logic [15:0] page_id,
  output logic [15:0] score,
  output logic        chk_err,
  output logic        fmt_err,
  output logic        timeout
);

  localparam logic [15:0] MAX_LEN_W = 16'(MAX_LEN);

  state_t         r_state;
  state_t         w_state_nxt;
  logic [1:0]     r_acnt;
  logic [23:0]    r_addr;
  logic [7:0]     r_len_h;
  logic [7:0]     r_sum_h;
  logic [15:0]    r_acc;
  logic [15:0]    r_remain;
  logic [15:0]    r_idx;
  logic [4:0][7:0] r_stage;

  logic [31:0]    w_addr_full;
  logic [15:0]    w_len_full;
  logic [15:0]    w_sum_full;
  logic [15:0]    w_acc_add;
  logic           w_resp;
  logic           w_chk;
  logic           w_fmt;
  logic           w_to;
  logic           w_expire;

  assign w_addr_full = {r_addr, rx_byte};
  assign w_len_full  = {r_len_h, rx_byte};
  assign w_sum_full  = {r_sum_h, rx_byte};
  assign w_acc_add   = r_acc + {8'h00, rx_byte};

`ifdef ZHIWEN_ACK_TIMEOUT_EN
  zhiwen_byte_timer #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_byte_timer (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_clr    (rx_vld),
    .i_en     (r_state != ST_HUNT_H0),
    .o_expire (w_expire)
  );
`else
  logic [31:0] w_unused_timeout_cfg;
  assign w_unused_timeout_cfg = 32'(TIMEOUT_CYC);
  assign w_expire             = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_HUNT_H0;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_resp      = 1'b0;
    w_chk       = 1'b0;
    w_fmt       = 1'b0;
    w_to        = 1'b0;
    if (rx_vld) begin
      case (r_state)
        ST_HUNT_H0: if (rx_byte == HDR0) w_state_nxt = ST_HUNT_H1;
        ST_HUNT_H1: begin
          if (rx_byte == HDR1)      w_state_nxt = ST_ADDR;
          else if (rx_byte == HDR0) w_state_nxt = ST_HUNT_H1;
          else                      w_state_nxt = ST_HUNT_H0;
        end
        ST_ADDR: begin
          if (r_acnt == 2'd3) begin
            if (w_addr_full != DEV_ADDR) begin
              w_fmt       = 1'b1;
              w_state_nxt = ST_HUNT_H0;
            end else begin
              w_state_nxt = ST_PID;
            end
          end
        end
        ST_PID: begin
          if (rx_byte != PID_ACK) begin
            w_fmt       = 1'b1;
            w_state_nxt = ST_HUNT_H0;
          end else begin
            w_state_nxt = ST_LEN_H;
          end
        end
        ST_LEN_H: w_state_nxt = ST_LEN_L;
        ST_LEN_L: begin
          if ((w_len_full < 16'd3) || (w_len_full > MAX_LEN_W)) begin
            w_fmt       = 1'b1;
            w_state_nxt = ST_HUNT_H0;
          end else begin
            w_state_nxt = ST_DATA;
          end
        end
        ST_DATA:  if (r_remain == 16'd1) w_state_nxt = ST_SUM_H;
        ST_SUM_H: w_state_nxt = ST_SUM_L;
        ST_SUM_L: begin
          if (w_sum_full == r_acc) w_resp = 1'b1;
          else                     w_chk  = 1'b1;
          w_state_nxt = ST_HUNT_H0;
        end
        default:  w_state_nxt = ST_HUNT_H0;
      endcase
    end else if (w_expire) begin
      w_to        = 1'b1;
      w_state_nxt = ST_HUNT_H0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy         <= 1'b0;
      resp_vld     <= 1'b0;
      chk_err      <= 1'b0;
      fmt_err      <= 1'b0;
      timeout      <= 1'b0;
      confirm_code <= '0;
      page_id      <= '0;
      score        <= '0;
      r_acnt       <= '0;
      r_addr       <= '0;
      r_len_h      <= '0;
      r_sum_h      <= '0;
      r_acc        <= '0;
      r_remain     <= '0;
      r_idx        <= '0;
      r_stage      <= '0;
    end else begin
      busy     <= (w_state_nxt != ST_HUNT_H0);
      resp_vld <= w_resp;
      chk_err  <= w_chk;
      fmt_err  <= w_fmt;
      timeout  <= w_to;
      if (rx_vld) begin
        case (r_state)
          ST_HUNT_H1: r_acnt <= '0;
          ST_ADDR: begin
            r_addr <= w_addr_full[23:0];
            r_acnt <= r_acnt + 2'd1;
          end
          // Staging is cleared per packet so absent payload bytes read as zero.
          ST_PID: begin
            r_acc   <= {8'h00, rx_byte};
            r_stage <= '0;
          end
          ST_LEN_H: begin
            r_len_h <= rx_byte;
            r_acc   <= w_acc_add;
          end
          ST_LEN_L: begin
            r_acc    <= w_acc_add;
            r_remain <= w_len_full - 16'd2;
            r_idx    <= '0;
          end
          ST_DATA: begin
            r_acc    <= w_acc_add;
            r_remain <= r_remain - 16'd1;
            r_idx    <= r_idx + 16'd1;
            if (r_idx < 16'd5) r_stage[r_idx[2:0]] <= rx_byte;
          end
          ST_SUM_H: r_sum_h <= rx_byte;
          ST_SUM_L: begin
            if (w_resp) begin
              confirm_code <= r_stage[0];
              page_id      <= {r_stage[1], r_stage[2]};
              score        <= {r_stage[3], r_stage[4]};
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
